encode_mul_arbiter: RTL and testbench

ENCODE_MUL_ARBITER -- requirements
Module: encode_mul_arbiter

---
 rtl/encode_mul_arb_pkg.sv | 12 +
 rtl/encode_mul_pipe.sv | 41 ++++
 rtl/encode_mul_arbiter.sv | 110 +++++++++++
 tb/tb_encode_mul_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/encode_mul_arb_pkg.sv
// Shared defaults and helpers for the round-robin multiplier arbiter.
package encode_mul_arb_pkg;
   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DIN0_WIDTH  = 40;
   localparam int DEF_DIN1_WIDTH  = 21;
   localparam int DEF_DOUT_WIDTH  = 60;
   localparam int DEF_MUL_LATENCY = 1;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/encode_mul_pipe.sv
// Signed STAGES-deep multiplier; the product wraps to P_W bits, no reset on data.
module encode_mul_pipe
   import encode_mul_arb_pkg::*;
#(
   parameter int A_W    = DEF_DIN0_WIDTH,
   parameter int B_W    = DEF_DIN1_WIDTH,
   parameter int P_W    = DEF_DOUT_WIDTH,
   parameter int STAGES = DEF_MUL_LATENCY
) (
   input  logic           clk,
   input  logic           ce,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [P_W-1:0] p
);
   localparam int FULL_W = A_W + B_W;
   localparam int EXT_W  = (FULL_W > P_W) ? FULL_W : P_W;

   logic signed [A_W-1:0]   a_s;
   logic signed [B_W-1:0]   b_s;
   logic signed [EXT_W-1:0] full_p0;
   logic signed [P_W-1:0]   prod_p [STAGES];

   function automatic logic signed [P_W-1:0] wrap_prod(input logic signed [EXT_W-1:0] full);
      return full[P_W-1:0];
   endfunction

   assign a_s     = a;
   assign b_s     = b;
   assign full_p0 = EXT_W'(a_s) * EXT_W'(b_s);

   // stage 0 captures the wrapped product; later stages only delay it
   always_ff @(posedge clk) begin
      if (ce) begin
         prod_p[0] <= wrap_prod(full_p0);
         for (int i = 1; i < STAGES; i++) prod_p[i] <= prod_p[i-1];
      end
   end

   assign p = prod_p[STAGES-1];
endmodule

// File: rtl/encode_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
module encode_mul_arbiter
   import encode_mul_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DIN0_WIDTH  = DEF_DIN0_WIDTH,
   parameter int DIN1_WIDTH  = DEF_DIN1_WIDTH,
   parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
   parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            ce,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]   req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]   req_din1,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [id_width(NUM_REQ)-1:0]    rsp_id,
   output logic [DOUT_WIDTH-1:0]           rsp_dout
);
   localparam int ID_W = id_width(NUM_REQ);

   logic                         advance;
   logic                         grant_vld;
   logic [ID_W-1:0]              grant_id;
   logic [ID_W-1:0]              cand;
   logic [NUM_REQ-1:0]           grant_oh;
   logic [ID_W-1:0]              ptr;
   logic [ID_W-1:0]              ptr_nxt;
   logic signed [DIN0_WIDTH-1:0] a_mux;
   logic signed [DIN1_WIDTH-1:0] b_mux;
   logic                         vld_p [MUL_LATENCY];
   logic [ID_W-1:0]              id_p  [MUL_LATENCY];
   logic [DOUT_WIDTH-1:0]        prod_out;

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
      logic [ID_W:0] s;
      s = {1'b0, base} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
      return s[ID_W-1:0];
   endfunction

   assign rsp_valid = vld_p[MUL_LATENCY-1] & ~reset;
   assign advance   = ce & (~rsp_valid | rsp_ready);
   assign req_ready = (advance & ~reset) ? grant_oh : '0;
   assign ptr_nxt   = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

   // grant depends only on valids and the pointer, never on operand data
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_idx(ptr, k);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_id  = cand;
         end
      end
      grant_oh = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
   end

   always_comb begin
      a_mux = '0;
      b_mux = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_id == ID_W'(k)) begin
            a_mux = req_din0[k*DIN0_WIDTH +: DIN0_WIDTH];
            b_mux = req_din1[k*DIN1_WIDTH +: DIN1_WIDTH];
         end
      end
   end

   // issue stage: control shift register and pointer, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) vld_p[i] <= 1'b0;
      end else if (advance) begin
         if (grant_vld) ptr <= ptr_nxt;
         vld_p[0] <= grant_vld;
         for (int i = 1; i < MUL_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         id_p[0] <= grant_id;
         for (int i = 1; i < MUL_LATENCY; i++) id_p[i] <= id_p[i-1];
      end
   end

   encode_mul_pipe #(
      .A_W    (DIN0_WIDTH),
      .B_W    (DIN1_WIDTH),
      .P_W    (DOUT_WIDTH),
      .STAGES (MUL_LATENCY)
   ) u_pipe (
      .clk (clk),
      .ce  (advance),
      .a   (a_mux),
      .b   (b_mux),
      .p   (prod_out)
   );

   assign rsp_id   = id_p[MUL_LATENCY-1];
   assign rsp_dout = prod_out;
endmodule

// File: tb/tb_encode_mul_arbiter.sv
// Randomized bench for encode_mul_arbiter against a transaction-level reference model.
module tb_encode_mul_arbiter;
   localparam int NR  = 4;
   localparam int AW  = 40;
   localparam int BW  = 21;
   localparam int PW  = 60;
   localparam int LAT = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              ce;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_din0;
   logic [NR*BW-1:0]  req_din1;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [PW-1:0]     rsp_dout;

   logic signed [AW-1:0] opa [NR];
   logic signed [BW-1:0] opb [NR];

   // reference model: slots in flight, slot LAT-1 is the visible response
   bit            s_vld  [LAT];
   int            s_id   [LAT];
   logic [PW-1:0] s_prod [LAT];
   int            m_ptr;

   int n_tests = 0;
   int n_fail  = 0;

   encode_mul_arbiter #(
      .NUM_REQ(NR), .DIN0_WIDTH(AW), .DIN1_WIDTH(BW),
      .DOUT_WIDTH(PW), .MUL_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_din0(req_din0), .req_din1(req_din1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_dout(rsp_dout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] model_prod(input int g);
      longint pa, pb, pr;
      pa = opa[g];
      pb = opb[g];
      pr = pa * pb;
      return pr[PW-1:0];
   endfunction

   // one clock: drive inputs, check against model, then advance the model at the edge
   task automatic cyc(input logic [NR-1:0] v, input logic rdy, input logic c, input logic r);
      bit            exp_rv, adv, found;
      int            g, idx;
      logic [NR-1:0] exp_ready;
      req_valid = v;
      rsp_ready = rdy;
      ce        = c;
      reset     = r;
      for (int i = 0; i < NR; i++) begin
         req_din0[i*AW +: AW] = opa[i];
         req_din1[i*BW +: BW] = opb[i];
      end
      #1;
      exp_rv = !r && s_vld[LAT-1];
      adv    = c && (!exp_rv || rdy);
      found  = 0;
      g      = 0;
      if (adv && !r) begin
         for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (!found && v[idx]) begin
               found = 1;
               g     = idx;
            end
         end
      end
      exp_ready = found ? NR'(1) << g : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("rsp_id", 64'(rsp_id), 64'(s_id[LAT-1]));
         chk("rsp_dout", 64'(rsp_dout), 64'(s_prod[LAT-1]));
      end
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < LAT; i++) s_vld[i] = 0;
         m_ptr = 0;
      end else if (adv) begin
         for (int i = LAT-1; i > 0; i--) begin
            s_vld[i]  = s_vld[i-1];
            s_id[i]   = s_id[i-1];
            s_prod[i] = s_prod[i-1];
         end
         s_vld[0]  = found;
         s_id[0]   = g;
         s_prod[0] = model_prod(g);
         if (found) m_ptr = (g + 1) % NR;
      end
      @(negedge clk);
   endtask

   function automatic logic signed [AW-1:0] rand_a();
      case ($urandom_range(0, 5))
         0: return {1'b1, {(AW-1){1'b0}}};
         1: return {1'b0, {(AW-1){1'b1}}};
         2: return '1;
         default: return AW'({$urandom, $urandom});
      endcase
   endfunction

   function automatic logic signed [BW-1:0] rand_b();
      case ($urandom_range(0, 5))
         0: return {1'b1, {(BW-1){1'b0}}};
         1: return {1'b0, {(BW-1){1'b1}}};
         2: return '1;
         default: return BW'($urandom);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < LAT; i++) begin
         s_vld[i]  = 0;
         s_id[i]   = 0;
         s_prod[i] = '0;
      end
      m_ptr = 0;
      for (int i = 0; i < NR; i++) begin
         opa[i] = AW'(i + 3);
         opb[i] = BW'(i + 5);
      end

      cyc('0, 1, 1, 1);
      cyc(4'b1111, 1, 1, 1);
      cyc('0, 1, 1, 0);

      // single request, -1 * -1
      opa[2] = '1;
      opb[2] = '1;
      cyc(4'b0100, 1, 1, 0);
      chk("single_valid", 64'(rsp_valid), 64'd1);
      chk("single_id", 64'(rsp_id), 64'd2);
      chk("single_dout", 64'(rsp_dout), 64'd1);
      cyc('0, 1, 1, 0);

      // all requesters valid, full throughput
      for (int i = 0; i < NR; i++) begin
         opa[i] = rand_a();
         opb[i] = rand_b();
      end
      for (int n = 0; n < 6; n++) cyc(4'b1111, 1, 1, 0);

      // backpressure with a result pending, then release
      for (int n = 0; n < 5; n++) cyc(4'b1111, 0, 1, 0);
      for (int n = 0; n < 4; n++) cyc(4'b1111, 1, 1, 0);
      cyc('0, 1, 1, 0);

      // wrap-around products
      opa[1] = {1'b1, {(AW-1){1'b0}}};
      opb[1] = {1'b1, {(BW-1){1'b0}}};
      cyc(4'b0010, 1, 1, 0);
      chk("wrap_min", 64'(rsp_dout), 64'h0800_0000_0000_0000);
      opa[3] = {1'b0, {(AW-1){1'b1}}};
      opb[3] = '1;
      cyc(4'b1000, 1, 1, 0);
      chk("wrap_max", 64'(rsp_dout), 64'h0FFF_FF80_0000_0001);
      cyc('0, 1, 1, 0);

      // clock enable low mid-stream
      cyc(4'b1111, 1, 1, 0);
      for (int n = 0; n < 3; n++) cyc(4'b1111, ($urandom_range(0, 1) == 1), 0, 0);
      cyc(4'b1111, 1, 1, 0);

      // reset with a result in flight
      cyc(4'b1111, 1, 1, 0);
      cyc(4'b1111, 1, 1, 1);
      req_valid = 4'b0110;
      reset     = 1'b0;
      ce        = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready", 64'(req_ready), 64'd2);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
      cyc(4'b0110, 1, 1, 0);
      cyc('0, 1, 1, 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NR; i++) begin
            opa[i] = rand_a();
            opb[i] = rand_b();
         end
         cyc(NR'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 99) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
